sha_sequencer: RTL and testbench

Round sequencer and block-buffer stage directly upstream of `sha_unit`. It latches one 512-bit message block and a 256-bit initial hash on a start request, then drives `round` and the matching round constant `Kt` through 64 rounds. It captures `H1` into a result register and signals completion. It owns all SHA-256 compression control; `sha_unit` stays a datapath.

---
 rtl/sha_pkg.sv | 33 +++
 rtl/sha_k_rom.sv | 17 +
 rtl/sha_sequencer.sv | 117 +++++++++++
 tb/tb_sha_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// Shared SHA-256 constants, state encoding and second-pass padding for the sequencer.
// Pure declarations: no latency, no flow control.
package sha_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    localparam logic [255:0] SHA_IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    // Padding for hashing a 256-bit digest as a one-block message.
    localparam logic [31:0]  PAD_ONE  = 32'h80000000;
    localparam logic [191:0] PAD_ZERO = 192'h0;
    localparam logic [31:0]  PAD_LEN  = 32'h00000100;

    localparam logic [31:0] K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [511:0] second_block(input logic [255:0] h);
        return {h, PAD_ONE, PAD_ZERO, PAD_LEN};
    endfunction

endpackage

// File: rtl/sha_k_rom.sv
// SHA-256 round-constant ROM: 6-bit round index to 32-bit K.
// Latency 1 cycle (registered output, async reset to 0); no backpressure.
module sha_k_rom
    import sha_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  idx,
    output logic [31:0] k
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) k <= 32'h0;
        else       k <= K_TABLE[idx];
    end

endmodule

// File: rtl/sha_sequencer.sv
// SHA-256 round sequencer: latches block/IV on start, drives round/Kt for 64 rounds, captures H1.
// Latency 65 cycles accept-to-done (130 with SHA_SEQUENCER_DOUBLE_EN); start ignored while busy, no queueing.
module sha_sequencer
    import sha_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [511:0] M_in,
    input  logic [255:0] H0_in,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest,
    output logic [5:0]   round,
    output logic [31:0]  Kt,
    output logic [511:0] M,
    output logic [255:0] H0,
    input  logic [255:0] H1
);

    state_t         state_q, state_d;
    logic [5:0]     round_q;
    logic [511:0]   m_q;
    logic [255:0]   h0_q;
    logic [255:0]   digest_q;
    logic           done_q;
    logic           accept;
    logic           finish;
`ifdef SHA_SEQUENCER_DOUBLE_EN
    logic           pass_q;
    logic           reload;
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
`ifdef SHA_SEQUENCER_DOUBLE_EN
        reload  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    accept  = 1'b1;
                end
            end
            S_RUN: begin
                if (round_q == 6'd63) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
`ifdef SHA_SEQUENCER_DOUBLE_EN
                // First pass feeds its own result back as a padded one-block message.
                if (pass_q) begin
                    state_d = S_IDLE;
                    finish  = 1'b1;
                end else begin
                    state_d = S_RUN;
                    reload  = 1'b1;
                end
`else
                state_d = S_IDLE;
                finish  = 1'b1;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            round_q  <= 6'd0;
            m_q      <= '0;
            h0_q     <= '0;
            digest_q <= '0;
            done_q   <= 1'b0;
`ifdef SHA_SEQUENCER_DOUBLE_EN
            pass_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            done_q  <= finish;
            if (accept) begin
                m_q     <= M_in;
                h0_q    <= H0_in;
                round_q <= 6'd0;
            end
            // Wraps to 0 on the edge that samples round 63.
            if (state_q == S_RUN) round_q <= round_q + 6'd1;
            if (finish) digest_q <= H1;
`ifdef SHA_SEQUENCER_DOUBLE_EN
            if (reload) begin
                m_q    <= second_block(H1);
                h0_q   <= SHA_IV;
                pass_q <= 1'b1;
            end
            if (finish) pass_q <= 1'b0;
`endif
        end
    end

    sha_k_rom u_k_rom (
        .clk   (clk),
        .reset (reset),
        .idx   (round_q),
        .k     (Kt)
    );

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign digest = digest_q;
    assign round  = round_q;
    assign M      = m_q;
    assign H0     = h0_q;

endmodule

// File: tb/tb_sha_sequencer.sv
// Self-checking bench for sha_sequencer with a behavioural SHA-256 compression standing in for sha_unit.
module tb_sha_sequencer;

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
`ifdef SHA_SEQUENCER_DOUBLE_EN
    localparam int LAT = 130;
`else
    localparam int LAT = 65;
`endif

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [511:0] M_in;
    logic [255:0] H0_in;
    logic         busy;
    logic         done;
    logic [255:0] digest;
    logic [5:0]   round;
    logic [31:0]  Kt;
    logic [511:0] M;
    logic [255:0] H0;
    logic [255:0] H1;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    sha_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .M_in   (M_in),
        .H0_in  (H0_in),
        .busy   (busy),
        .done   (done),
        .digest (digest),
        .round  (round),
        .Kt     (Kt),
        .M      (M),
        .H0     (H0),
        .H1     (H1)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [511:0] m, input logic [255:0] h);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = h[255 - 32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        return {h[255:224] + v[0], h[223:192] + v[1], h[191:160] + v[2], h[159:128] + v[3],
                h[127:96]  + v[4], h[95:64]   + v[5], h[63:32]    + v[6], h[31:0]     + v[7]};
    endfunction

    function automatic logic [255:0] ref_hash(input logic [511:0] m, input logic [255:0] h0);
`ifdef SHA_SEQUENCER_DOUBLE_EN
        return compress({compress(m, h0), 32'h80000000, 192'h0, 32'h00000100}, IV);
`else
        return compress(m, h0);
`endif
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Round index expected c edges after the accept edge (each pass is 64 rounds plus a capture cycle).
    function automatic int exp_round(input int c);
        int r;
        if (c < 0) return 0;
        r = c % 65;
        return (r == 64) ? 0 : r;
    endfunction

    // H1 is only meaningful while sha_unit would hold a finished result (round 0); otherwise it is scrambled.
    always_comb begin
        H1 = compress(M, H0);
        if (round != 6'd0) H1 = ~H1;
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Called at the first falling edge after the accept edge; returns edges since accept when done is seen.
    task automatic wait_done(input logic [511:0] m, input bit poke, output int cyc);
        cyc = 0;
        while (cyc <= LAT + 20) begin
            start = poke && (cyc == 10 || cyc == 30 || cyc == 60);
            M_in  = rand512();
            H0_in = rand512()[255:0];
            chk("round", round, exp_round(cyc));
            chk("kt", Kt, KT[exp_round(cyc - 1)]);
            chk("busy", busy, (cyc < LAT));
            if (cyc == 10) chk("m_latched", M, m);
            if (done) break;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    typedef struct {
        string        name;
        logic [511:0] m;
        logic [255:0] h0;
        logic [255:0] exp;
        bit           poke;
    } vec_t;

    vec_t vecs [6];
    int   cyc;
    int   done_cnt;
    logic [511:0] abc_m;
    logic [255:0] abc_d;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        abc_m = {32'h61626380, 448'h0, 32'h00000018};
`ifdef SHA_SEQUENCER_DOUBLE_EN
        abc_d = 256'h4f8b42c2_2dd3729b_519ba6f6_8d2da7cc_5b2d606d_05daed5a_d5128cc0_3e6c6358;
`else
        abc_d = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
`endif
        vecs[0] = '{"abc", abc_m, IV, abc_d, 1'b0};
`ifdef SHA_SEQUENCER_DOUBLE_EN
        vecs[1] = '{"empty", {32'h80000000, 480'h0}, IV, ref_hash({32'h80000000, 480'h0}, IV), 1'b1};
`else
        vecs[1] = '{"empty", {32'h80000000, 480'h0}, IV,
                    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855, 1'b1};
`endif
        for (int i = 2; i < 6; i++) begin
            vecs[i].name = "random";
            vecs[i].m    = rand512();
            vecs[i].h0   = (i % 2 == 0) ? IV : rand512()[255:0];
            vecs[i].exp  = ref_hash(vecs[i].m, vecs[i].h0);
            vecs[i].poke = (i == 3);
        end

        reset = 1'b1; start = 1'b0; M_in = '0; H0_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_round", round, 0);
        chk("rst_kt", Kt, 0);
        chk("rst_digest", digest, 0);
        chk("rst_m", M, 0);
        chk("rst_h0", H0, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            M_in = vecs[i].m; H0_in = vecs[i].h0; start = 1'b1;
            @(negedge clk);
            wait_done(vecs[i].m, vecs[i].poke, cyc);
            chk({vecs[i].name, "_latency"}, cyc, LAT);
            chk({vecs[i].name, "_digest"}, digest, vecs[i].exp);
            @(negedge clk);
            chk({vecs[i].name, "_done_pulse"}, done, 0);
            chk({vecs[i].name, "_digest_hold"}, digest, vecs[i].exp);
        end

        // Back-to-back: restart in the done cycle.
        M_in = vecs[1].m; H0_in = IV; start = 1'b1;
        @(negedge clk);
        wait_done(vecs[1].m, 1'b0, cyc);
        chk("b2b_first_latency", cyc, LAT);
        M_in = abc_m; H0_in = IV; start = 1'b1;
        @(negedge clk);
        wait_done(abc_m, 1'b0, cyc);
        chk("b2b_second_latency", cyc, LAT);
        chk("b2b_second_digest", digest, abc_d);

        // Reset mid-operation at round 40.
        @(negedge clk);
        M_in = vecs[2].m; H0_in = vecs[2].h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("pre_reset_round", round, 40);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_round", round, 0);
        chk("mid_rst_kt", Kt, 0);
        chk("mid_rst_digest", digest, 0);
        chk("mid_rst_m", M, 0);
        chk("mid_rst_h0", H0, 0);
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("no_done_after_reset", done_cnt, 0);
        chk("idle_after_reset", busy, 0);

        M_in = abc_m; H0_in = IV; start = 1'b1;
        @(negedge clk);
        wait_done(abc_m, 1'b0, cyc);
        chk("post_reset_latency", cyc, LAT);
        chk("post_reset_digest", digest, abc_d);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
